// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port general register file with a pending-write
// scoreboard. It sits in the decode stage. It serves operand reads for any
// number of issue slots and accepts several writebacks per cycle. A busy bit
// per register marks an in-flight producer, so hazard logic can stall on rbusy.
//
// Parameters
//   DW   data width of each register
//   AW   address width; depth = 2**AW registers
//   NRD  number of read ports
//   NWR  number of write ports; a higher index has higher priority
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; clears all registers and busy bits
//   raddr     in   NRD*AW read addresses, port i at [i*AW +: AW]
//   rdata     out  NRD*DW read data, port i at [i*DW +: DW] (combinational)
//   rbusy     out  NRD busy flags for the addressed registers (combinational)
//   we        in   NWR write enables
//   waddr     in   NWR*AW write addresses
//   wdata     in   NWR*DW write data
//   iss_vld   in   an instruction with a destination register issues
//   iss_addr  in   AW destination register of the issuing instruction
//   flush     in   clears every busy bit (data writes still commit)
//
// Build option
//   RF_BYPASS_EN  when defined, same-cycle writes are forwarded to the read
//                 ports, and a matching write masks the busy flag
//                 (write-through). When undefined, reads see only committed
//                 state.
//
// Register 0 is hard-wired: it reads as 0 and is never busy. Writes and
// issues to it are dropped.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int NWR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic              iss_vld,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // ------------------------------------------------------------------
    // Write commit. Ports are visited in ascending order. When two ports
    // hit the same address, the later (higher-index) assignment overwrites
    // the earlier one, so the highest-index port wins. Writes to different
    // addresses all land.
    // ------------------------------------------------------------------
    always_comb begin : wr_comb
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*AW +: AW] != '0)) begin
                mem_d[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard update. Flush beats everything. Otherwise writebacks
    // clear first, and the issue is applied last. A new producer issued in
    // the same cycle as the old producer's writeback therefore keeps the
    // register busy.
    // ------------------------------------------------------------------
    always_comb begin : busy_comb
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j]) begin
                    busy_d[waddr[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_vld) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        // Register 0 never carries a producer.
        busy_d[0] = 1'b0;
    end

    // Reset wins over flush, writes and issue in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. These are fully combinational from the committed state.
    // With the bypass build, a write in flight this cycle overrides the
    // stored value, and the highest-index matching port wins. The same
    // write also masks the busy flag, because its producer is completing
    // right now.
    // ------------------------------------------------------------------
    logic [AW-1:0] ra;

    always_comb begin : rd_comb
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            if (ra != '0) begin
                rdata[i*DW +: DW] = mem_q[ra];
                rbusy[i]          = busy_q[ra];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (waddr[j*AW +: AW] == ra)) begin
                        rdata[i*DW +: DW] = wdata[j*DW +: DW];
                        rbusy[i]          = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule
